sockit_spi_slv: RTL and testbench

SPI slave (responder) serializer/deserializer, the far-end counterpart of the sockit SPI master serializer. It runs entirely in the system clock domain. SCLK, SS_N and MOSI are oversampled through synchronizers and their edges detected. Received words are delivered on a valid/ready read stream (sdr), and transmit words are taken from a valid/ready write stream (sdw) through a one-entry prefetch buffer. It supports CPOL/CPHA modes 0–3, MSB- or LSB-first ordering, and sticky overflow and underflow flags.

---
 rtl/sockit_spi_slv.sv | 180 ++++++++++++++++++
 tb/tb_sockit_spi_slv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sockit_spi_slv.sv
// SPI responder serializer/deserializer running in the system clock domain.
// Pins are oversampled; rx words go out on sdr, tx words come from sdw via a one-entry buffer.
module sockit_spi_slv #(
  parameter int unsigned SDW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_pol,
  input  logic           cfg_pha,
  input  logic           cfg_lsb,
  input  logic           sta_clr,
  input  logic           sdw_vld,
  input  logic [SDW-1:0] sdw_dat,
  output logic           sdw_rdy,
  output logic           sdr_vld,
  output logic [SDW-1:0] sdr_dat,
  input  logic           sdr_rdy,
  input  logic           spi_sclk_i,
  input  logic           spi_ssn_i,
  input  logic           spi_mosi_i,
  output logic           spi_miso_o,
  output logic           spi_miso_e,
  output logic           bsy,
  output logic           ovf,
  output logic           udf
);

  localparam int unsigned CW = $clog2(SDW);

  // ST_WAIT: after reset, hold off until SS_N has been seen high through the synchronizer
  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_SEL} state_t;

  state_t         state_q, state_d;
  logic [2:0]     sclk_q, ssn_q;
  logic [1:0]     mosi_q, fill_q;
  logic           pol_q, pol_d, pha_q, pha_d, lsb_q, lsb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SDW-1:0] rx_q, rx_d, tx_q, tx_d, buf_q, buf_d, sdr_dat_q, sdr_dat_d;
  logic           buf_emp_q, buf_emp_d, sdr_vld_q, sdr_vld_d;
  logic           miso_q, miso_d, sel_q, sel_d, ovf_q, ovf_d, udf_q, udf_d;

  logic act_c, sel_fall_c, sclk_tgl_c, lead_c, trail_c, smp_c, shf_c;
  logic word_done_c, load_c, hs_c, ovf_set_c, udf_set_c;

  assign act_c       = (state_q == ST_SEL) & ~ssn_q[1];
  assign sel_fall_c  = (state_q == ST_IDLE) & ssn_q[2] & ~ssn_q[1];
  assign sclk_tgl_c  = act_c & (sclk_q[1] ^ sclk_q[2]);
  assign lead_c      = sclk_tgl_c & (sclk_q[1] != pol_q);
  assign trail_c     = sclk_tgl_c & (sclk_q[1] == pol_q);
  assign smp_c       = pha_q ? trail_c : lead_c;
  assign shf_c       = pha_q ? lead_c : trail_c;
  assign word_done_c = smp_c & (cnt_q == CW'(SDW - 1));
  // A shift edge with the counter at zero is the start of a word in both phases
  assign load_c      = (sel_fall_c & ~cfg_pha) | (shf_c & (cnt_q == '0));
  assign hs_c        = sdw_vld & buf_emp_q;

  always_comb begin
    state_d     = state_q;
    pol_d       = pol_q;
    pha_d       = pha_q;
    lsb_d       = lsb_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    buf_d       = buf_q;
    buf_emp_d   = buf_emp_q;
    sdr_dat_d   = sdr_dat_q;
    sdr_vld_d   = sdr_vld_q;
    ovf_set_c   = 1'b0;
    udf_set_c   = 1'b0;

    case (state_q)
      ST_WAIT: if (fill_q[1] & ssn_q[1]) state_d = ST_IDLE;
      ST_IDLE: if (sel_fall_c) begin
        state_d = ST_SEL;
        pol_d   = cfg_pol;
        pha_d   = cfg_pha;
        lsb_d   = cfg_lsb;
      end
      ST_SEL:  if (ssn_q[1]) state_d = ST_IDLE;
      default: state_d = ST_WAIT;
    endcase

    // Receive shift and bit count; a deselect discards the partial word
    if (!act_c) begin
      cnt_d = '0;
      rx_d  = '0;
    end else if (smp_c) begin
      rx_d  = lsb_q ? {mosi_q[1], rx_q[SDW-1:1]} : {rx_q[SDW-2:0], mosi_q[1]};
      cnt_d = word_done_c ? '0 : cnt_q + CW'(1);
    end

    if (sdr_vld_q & sdr_rdy) sdr_vld_d = 1'b0;
    if (word_done_c) begin
      if (!sdr_vld_q || sdr_rdy) begin
        sdr_dat_d = rx_d;
        sdr_vld_d = 1'b1;
      end else begin
        ovf_set_c = 1'b1;
      end
    end

    if (!act_c) tx_d = '0;
    if (load_c) begin
      if (!buf_emp_q) begin
        tx_d      = buf_q;
        buf_emp_d = 1'b1;
      end else begin
        tx_d      = '1;
        udf_set_c = 1'b1;
      end
    end else if (shf_c) begin
      tx_d = lsb_q ? {1'b1, tx_q[SDW-1:1]} : {tx_q[SDW-2:0], 1'b1};
    end

    if (hs_c) begin
      buf_d     = sdw_dat;
      buf_emp_d = 1'b0;
    end

    miso_d = lsb_q ? tx_q[0] : tx_q[SDW-1];
    sel_d  = (state_d == ST_SEL);
    ovf_d  = (ovf_q & ~sta_clr) | ovf_set_c;
    udf_d  = (udf_q & ~sta_clr) | udf_set_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_q    <= '0;
      ssn_q     <= '1;
      mosi_q    <= '0;
      fill_q    <= '0;
      state_q   <= ST_WAIT;
      pol_q     <= 1'b0;
      pha_q     <= 1'b0;
      lsb_q     <= 1'b0;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      buf_q     <= '0;
      buf_emp_q <= 1'b1;
      sdr_dat_q <= '0;
      sdr_vld_q <= 1'b0;
      miso_q    <= 1'b0;
      sel_q     <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], spi_sclk_i};
      ssn_q     <= {ssn_q[1:0], spi_ssn_i};
      mosi_q    <= {mosi_q[0], spi_mosi_i};
      fill_q    <= {fill_q[0], 1'b1};
      state_q   <= state_d;
      pol_q     <= pol_d;
      pha_q     <= pha_d;
      lsb_q     <= lsb_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      buf_q     <= buf_d;
      buf_emp_q <= buf_emp_d;
      sdr_dat_q <= sdr_dat_d;
      sdr_vld_q <= sdr_vld_d;
      miso_q    <= miso_d;
      sel_q     <= sel_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign sdw_rdy    = buf_emp_q;
  assign sdr_vld    = sdr_vld_q;
  assign sdr_dat    = sdr_dat_q;
  assign spi_miso_o = miso_q;
  assign spi_miso_e = sel_q;
  assign bsy        = sel_q;
  assign ovf        = ovf_q;
  assign udf        = udf_q;

endmodule

// File: tb/tb_sockit_spi_slv.sv
// Directed bench for sockit_spi_slv: a bit-banged SPI master drives the pins at f_clk/12.
module tb_sockit_spi_slv;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst, cfg_pol, cfg_pha, cfg_lsb, sta_clr;
  logic       sdw_vld, sdw_rdy, sdr_vld, sdr_rdy;
  logic [7:0] sdw_dat, sdr_dat;
  logic       spi_sclk_i, spi_ssn_i, spi_mosi_i, spi_miso_o, spi_miso_e;
  logic       bsy, ovf, udf;
  logic [7:0] m1, m2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sockit_spi_slv #(.SDW(8)) dut (
    .clk(clk), .rst(rst), .cfg_pol(cfg_pol), .cfg_pha(cfg_pha), .cfg_lsb(cfg_lsb),
    .sta_clr(sta_clr), .sdw_vld(sdw_vld), .sdw_dat(sdw_dat), .sdw_rdy(sdw_rdy),
    .sdr_vld(sdr_vld), .sdr_dat(sdr_dat), .sdr_rdy(sdr_rdy),
    .spi_sclk_i(spi_sclk_i), .spi_ssn_i(spi_ssn_i), .spi_mosi_i(spi_mosi_i),
    .spi_miso_o(spi_miso_o), .spi_miso_e(spi_miso_e),
    .bsy(bsy), .ovf(ovf), .udf(udf)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_buf(input logic [7:0] d);
    sdw_dat = d; sdw_vld = 1'b1;
    clks(1);
    sdw_vld = 1'b0;
  endtask

  task automatic pop();
    sdr_rdy = 1'b1;
    clks(1);
    sdr_rdy = 1'b0;
  endtask

  task automatic clr();
    sta_clr = 1'b1;
    clks(1);
    sta_clr = 1'b0;
  endtask

  task automatic sel();
    spi_sclk_i = cfg_pol;
    clks(H);
    spi_ssn_i = 1'b0;
    clks(8);
  endtask

  task automatic desel();
    clks(H);
    spi_ssn_i = 1'b1;
    clks(8);
  endtask

  // Master shifts n bits of d out on MOSI and collects MISO at its own sample edge
  task automatic xfer(input logic [7:0] d, input int n, output logic [7:0] m);
    int bi;
    m = '0;
    for (int i = 0; i < n; i++) begin
      bi = cfg_lsb ? i : 7 - i;
      if (!cfg_pha) spi_mosi_i = d[bi];
      clks(H);
      spi_sclk_i = ~cfg_pol;
      if (cfg_pha) spi_mosi_i = d[bi];
      else         m[bi] = spi_miso_o;
      clks(H);
      spi_sclk_i = cfg_pol;
      if (cfg_pha) m[bi] = spi_miso_o;
    end
  endtask

  task automatic run_mode(input logic pol, input logic pha, input string tag);
    cfg_pol = pol; cfg_pha = pha; cfg_lsb = 1'b1;
    write_buf(8'h12);
    sel();
    fork
      xfer(8'h81, 8, m1);
      begin clks(30); write_buf(8'h34); end
    join
    clks(5);
    chk({tag, "_vld1"}, 32'(sdr_vld), 32'h1);
    chk({tag, "_rx1"}, 32'(sdr_dat), 32'h81);
    chk({tag, "_tx1"}, 32'(m1), 32'h12);
    pop();
    xfer(8'h7E, 8, m2);
    clks(5);
    chk({tag, "_vld2"}, 32'(sdr_vld), 32'h1);
    chk({tag, "_rx2"}, 32'(sdr_dat), 32'h7E);
    chk({tag, "_tx2"}, 32'(m2), 32'h34);
    pop();
    desel();
  endtask

  initial begin
    rst = 1'b0; cfg_pol = 1'b0; cfg_pha = 1'b0; cfg_lsb = 1'b0; sta_clr = 1'b0;
    sdw_vld = 1'b0; sdw_dat = '0; sdr_rdy = 1'b0;
    spi_sclk_i = 1'b0; spi_ssn_i = 1'b1; spi_mosi_i = 1'b0;
    clks(5);
    chk("rst_sdw_rdy", 32'(sdw_rdy), 32'h1);
    chk("rst_sdr_vld", 32'(sdr_vld), 32'h0);
    chk("rst_sdr_dat", 32'(sdr_dat), 32'h0);
    chk("rst_miso", 32'(spi_miso_o), 32'h0);
    chk("rst_miso_e", 32'(spi_miso_e), 32'h0);
    chk("rst_bsy", 32'(bsy), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    chk("rst_udf", 32'(udf), 32'h0);
    rst = 1'b1;
    clks(10);

    // Mode 0, MSB first
    write_buf(8'hA5);
    chk("m0_rdy_full", 32'(sdw_rdy), 32'h0);
    sel();
    chk("m0_rdy_load", 32'(sdw_rdy), 32'h1);
    chk("m0_bsy", 32'(bsy), 32'h1);
    chk("m0_miso_e", 32'(spi_miso_e), 32'h1);
    xfer(8'h3C, 8, m1);
    chk("m0_tx", 32'(m1), 32'hA5);
    chk("m0_vld", 32'(sdr_vld), 32'h1);
    chk("m0_rx", 32'(sdr_dat), 32'h3C);
    pop();
    chk("m0_vld_clr", 32'(sdr_vld), 32'h0);
    desel();
    chk("m0_bsy_off", 32'(bsy), 32'h0);

    run_mode(1'b0, 1'b1, "m1");
    run_mode(1'b1, 1'b0, "m2");
    run_mode(1'b1, 1'b1, "m3");

    // Overflow
    cfg_pol = 1'b0; cfg_pha = 1'b0; cfg_lsb = 1'b0;
    clr();
    sel();
    xfer(8'h11, 8, m1);
    xfer(8'h22, 8, m2);
    clks(5);
    chk("ovf_dat", 32'(sdr_dat), 32'h11);
    chk("ovf_vld", 32'(sdr_vld), 32'h1);
    chk("ovf_set", 32'(ovf), 32'h1);
    clr();
    chk("ovf_clr", 32'(ovf), 32'h0);
    pop();
    desel();

    // Underflow, then buffer filled mid-word
    clr();
    chk("udf_clr", 32'(udf), 32'h0);
    sel();
    chk("udf_set", 32'(udf), 32'h1);
    fork
      xfer(8'h00, 8, m1);
      begin clks(30); write_buf(8'h5C); end
    join
    chk("udf_tx1", 32'(m1), 32'hFF);
    pop();
    xfer(8'h00, 8, m2);
    chk("udf_tx2", 32'(m2), 32'h5C);
    pop();
    desel();

    // Partial word aborted by SS_N, then a full word
    clr();
    write_buf(8'h00);
    sel();
    xfer(8'hFF, 3, m1);
    desel();
    clks(5);
    chk("part_vld", 32'(sdr_vld), 32'h0);
    write_buf(8'h66);
    sel();
    write_buf(8'h77);
    xfer(8'h5A, 8, m1);
    clks(5);
    chk("part_vld2", 32'(sdr_vld), 32'h1);
    chk("part_rx", 32'(sdr_dat), 32'h5A);
    chk("part_tx", 32'(m1), 32'h66);
    chk("part_ovf", 32'(ovf), 32'h0);
    chk("part_udf", 32'(udf), 32'h0);
    pop();
    desel();

    // Reset during bit 4
    write_buf(8'h99);
    sel();
    write_buf(8'hAA);
    fork
      xfer(8'hF0, 8, m1);
      begin
        clks(3 * 2 * H + 3);
        rst = 1'b0;
        clks(1);
        chk("mrst_sdw_rdy", 32'(sdw_rdy), 32'h1);
        chk("mrst_sdr_vld", 32'(sdr_vld), 32'h0);
        chk("mrst_sdr_dat", 32'(sdr_dat), 32'h0);
        chk("mrst_miso", 32'(spi_miso_o), 32'h0);
        chk("mrst_miso_e", 32'(spi_miso_e), 32'h0);
        chk("mrst_bsy", 32'(bsy), 32'h0);
        chk("mrst_ovf", 32'(ovf), 32'h0);
        chk("mrst_udf", 32'(udf), 32'h0);
        clks(2);
        rst = 1'b1;
      end
    join
    desel();
    sel();
    xfer(8'hC3, 8, m1);
    clks(5);
    chk("post_rst_vld", 32'(sdr_vld), 32'h1);
    chk("post_rst_rx", 32'(sdr_dat), 32'hC3);
    pop();
    desel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
